// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ write-back
// requesters; the accepted write is registered onto WE/WriteReg/WriteData.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      ReqValid,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    output logic [NREQ-1:0]      ReqReady,
    input  logic                 Stall,
    output logic                 WE,
    output logic [AW-1:0]        WriteReg,
    output logic [DW-1:0]        WriteData,
    output logic [1:0]           GrantId,
    output logic [15:0]          GrantCount
);

    logic [1:0]    ptr;
    logic          win_vld;
    logic [1:0]    win_id;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          accept;

    // Scan downward so the last hit is the one closest to ptr in wrap order.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        win_addr = '0;
        win_data = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (ReqValid[idx]) begin
                win_vld  = 1'b1;
                win_id   = idx[1:0];
                win_addr = ReqAddr[idx*AW +: AW];
                win_data = ReqData[idx*DW +: DW];
            end
        end
    end

    assign accept = win_vld && !Stall && rst_n;

    always_comb begin
        ReqReady = '0;
        if (accept) ReqReady[win_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            WE         <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
            GrantId    <= '0;
            GrantCount <= '0;
        end else if (accept) begin
            WE        <= 1'b1;
            WriteReg  <= win_addr;
            WriteData <= win_data;
            GrantId   <= win_id;
            ptr       <= (win_id == 2'(NREQ - 1)) ? 2'd0 : win_id + 2'd1;
            if (GrantCount != 16'hFFFF) GrantCount <= GrantCount + 16'd1;
        end else begin
            WE <= 1'b0;
        end
    end

endmodule
